// File: rtl/frag_tile_scheduler.sv
// rtl/frag_tile_scheduler.sv - splits a fragment bounding box into row-major tiles
// One box is accepted in IDLE; its tiles are then emitted in EMIT under a valid/ready handshake.
module frag_tile_scheduler #(
    parameter logic [15:0] TILE_STEP = 16'd128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nd,
    output logic        us_rfd,
    input  logic [15:0] fp_min_x,
    input  logic [15:0] fp_max_x,
    input  logic [15:0] fp_min_y,
    input  logic [15:0] fp_max_y,
    input  logic        ds_rfd,
    output logic        rdy,
    output logic [15:0] tile_min_x,
    output logic [15:0] tile_max_x,
    output logic [15:0] tile_min_y,
    output logic [15:0] tile_max_y,
    output logic        last,
    output logic        err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    logic [0:0]  r_state;
    logic [15:0] r_box_min_x;
    logic [15:0] r_box_max_x;
    logic [15:0] r_box_max_y;
    logic [15:0] r_tile_min_x;
    logic [15:0] r_tile_max_x;
    logic [15:0] r_tile_min_y;
    logic [15:0] r_tile_max_y;
    logic        r_last;
    logic        r_err;

    logic        w_load;
    logic        w_accept;
    logic        w_degen;
    logic [15:0] w_ld_max_x;
    logic [15:0] w_ld_max_y;
    logic [15:0] w_nx;
    logic [15:0] w_nx_max;
    logic [15:0] w_ny;
    logic [15:0] w_ny_max;
    logic [15:0] w_row_max_x;
    logic        w_row_end;

    // Tile edge = cur + STEP - 1, evaluated in 17 bits so a carry clamps to the box edge.
    function automatic logic [15:0] f_clamp(input logic [15:0] cur, input logic [15:0] bmax);
        logic [16:0] sum;
        sum = {1'b0, cur} + {1'b0, TILE_STEP} - 17'd1;
        if (sum[16] || (sum[15:0] > bmax))
            f_clamp = bmax;
        else
            f_clamp = sum[15:0];
    endfunction

    assign w_degen     = (fp_min_x > fp_max_x) || (fp_min_y > fp_max_y);
    assign w_load      = (r_state == S_IDLE) && nd && !w_degen;
    assign w_accept    = (r_state == S_EMIT) && ds_rfd;
    assign w_ld_max_x  = f_clamp(fp_min_x, fp_max_x);
    assign w_ld_max_y  = f_clamp(fp_min_y, fp_max_y);
    assign w_nx        = r_tile_min_x + TILE_STEP;
    assign w_nx_max    = f_clamp(w_nx, r_box_max_x);
    assign w_ny        = r_tile_min_y + TILE_STEP;
    assign w_ny_max    = f_clamp(w_ny, r_box_max_y);
    assign w_row_max_x = f_clamp(r_box_min_x, r_box_max_x);
    assign w_row_end   = (r_tile_max_x == r_box_max_x);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_box_min_x  <= 16'h0000;
            r_box_max_x  <= 16'h0000;
            r_box_max_y  <= 16'h0000;
            r_tile_min_x <= 16'h0000;
            r_tile_max_x <= 16'h0000;
            r_tile_min_y <= 16'h0000;
            r_tile_max_y <= 16'h0000;
            r_last       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err <= (r_state == S_IDLE) && nd && w_degen;
            if (w_load) begin
                r_state      <= S_EMIT;
                r_box_min_x  <= fp_min_x;
                r_box_max_x  <= fp_max_x;
                r_box_max_y  <= fp_max_y;
                r_tile_min_x <= fp_min_x;
                r_tile_max_x <= w_ld_max_x;
                r_tile_min_y <= fp_min_y;
                r_tile_max_y <= w_ld_max_y;
                r_last       <= (w_ld_max_x == fp_max_x) && (w_ld_max_y == fp_max_y);
            end else if (w_accept) begin
                if (r_last) begin
                    r_state <= S_IDLE;
                    r_last  <= 1'b0;
                end else if (!w_row_end) begin
                    r_tile_min_x <= w_nx;
                    r_tile_max_x <= w_nx_max;
                    r_last       <= (w_nx_max == r_box_max_x) && (r_tile_max_y == r_box_max_y);
                end else begin
                    r_tile_min_x <= r_box_min_x;
                    r_tile_max_x <= w_row_max_x;
                    r_tile_min_y <= w_ny;
                    r_tile_max_y <= w_ny_max;
                    r_last       <= (w_row_max_x == r_box_max_x) && (w_ny_max == r_box_max_y);
                end
            end
        end
    end

    assign us_rfd     = (r_state == S_IDLE);
    assign rdy        = (r_state == S_EMIT);
    assign tile_min_x = r_tile_min_x;
    assign tile_max_x = r_tile_max_x;
    assign tile_min_y = r_tile_min_y;
    assign tile_max_y = r_tile_max_y;
    assign last       = r_last;
    assign err        = r_err;

endmodule

// File: tb/tb_frag_tile_scheduler.sv
// tb/tb_frag_tile_scheduler.sv - directed self-checking bench for frag_tile_scheduler
module tb_frag_tile_scheduler;

    logic        clk;
    logic        rst;
    logic        nd;
    logic        us_rfd;
    logic [15:0] fp_min_x, fp_max_x, fp_min_y, fp_max_y;
    logic        ds_rfd;
    logic        rdy;
    logic [15:0] tile_min_x, tile_max_x, tile_min_y, tile_max_y;
    logic        last;
    logic        err;

    int vectors;
    int miscompares;

    frag_tile_scheduler #(.TILE_STEP(16'd128)) dut (
        .clk(clk), .rst(rst), .nd(nd), .us_rfd(us_rfd),
        .fp_min_x(fp_min_x), .fp_max_x(fp_max_x), .fp_min_y(fp_min_y), .fp_max_y(fp_max_y),
        .ds_rfd(ds_rfd), .rdy(rdy),
        .tile_min_x(tile_min_x), .tile_max_x(tile_max_x),
        .tile_min_y(tile_min_y), .tile_max_y(tile_max_y),
        .last(last), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_box(input logic [15:0] x0, input logic [15:0] x1,
                            input logic [15:0] y0, input logic [15:0] y1);
        int n;
        fp_min_x = x0; fp_max_x = x1; fp_min_y = y0; fp_max_y = y1;
        nd = 1'b1;
        n = 0;
        while (!us_rfd && n < 50) begin
            tick();
            n++;
        end
        vectors++;
        if (!us_rfd) begin
            miscompares++;
            $display("FAIL send_box_timeout: us_rfd=%b required 1", us_rfd);
        end
        tick();
        nd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; nd = 1'b0; ds_rfd = 1'b0;
        fp_min_x = 0; fp_max_x = 0; fp_min_y = 0; fp_max_y = 0;
        tick(); tick();
        rst = 1'b0;
        vectors++;
        if ({us_rfd, rdy, last, err} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_flags: us_rfd/rdy/last/err=%b required 1000", {us_rfd, rdy, last, err});
        end
        vectors++;
        if ({tile_min_x, tile_max_x, tile_min_y, tile_max_y} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_tiles: %h required 0", {tile_min_x, tile_max_x, tile_min_y, tile_max_y});
        end
    endtask

    task automatic test_single_tile();
        ds_rfd = 1'b1;
        send_box(16'd0, 16'd127, 16'd0, 16'd127);
        vectors++;
        if ({rdy, last, tile_min_x, tile_max_x, tile_min_y, tile_max_y} !== {2'b11, 16'd0, 16'd127, 16'd0, 16'd127}) begin
            miscompares++;
            $display("FAIL single_tile: rdy=%b last=%b tile=%0d,%0d,%0d,%0d required 1 1 0,127,0,127",
                     rdy, last, tile_min_x, tile_max_x, tile_min_y, tile_max_y);
        end
        tick();
        vectors++;
        if ({us_rfd, rdy} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_after: us_rfd=%b rdy=%b required 1 0", us_rfd, rdy);
        end
        send_box(16'd40, 16'd40, 16'd7, 16'd7);
        vectors++;
        if ({rdy, last, tile_min_x, tile_max_x, tile_min_y, tile_max_y} !== {2'b11, 16'd40, 16'd40, 16'd7, 16'd7}) begin
            miscompares++;
            $display("FAIL single_pixel: rdy=%b last=%b tile=%0d,%0d,%0d,%0d required 1 1 40,40,7,7",
                     rdy, last, tile_min_x, tile_max_x, tile_min_y, tile_max_y);
        end
        tick();
    endtask

    task automatic test_multi_tile(input int stall_idx);
        logic [15:0] ex [6][4];
        ex[0] = '{16'd0,   16'd127, 16'd0,   16'd127};
        ex[1] = '{16'd128, 16'd255, 16'd0,   16'd127};
        ex[2] = '{16'd256, 16'd300, 16'd0,   16'd127};
        ex[3] = '{16'd0,   16'd127, 16'd128, 16'd130};
        ex[4] = '{16'd128, 16'd255, 16'd128, 16'd130};
        ex[5] = '{16'd256, 16'd300, 16'd128, 16'd130};
        ds_rfd = 1'b1;
        send_box(16'd0, 16'd300, 16'd0, 16'd130);
        // Junk upstream traffic while emitting must be ignored.
        fp_min_x = 16'd5; fp_max_x = 16'd9; fp_min_y = 16'd5; fp_max_y = 16'd9;
        nd = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == stall_idx) begin
                ds_rfd = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    vectors++;
                    if ({rdy, last, tile_min_x, tile_max_x, tile_min_y, tile_max_y} !==
                        {2'b10, ex[i][0], ex[i][1], ex[i][2], ex[i][3]}) begin
                        miscompares++;
                        $display("FAIL stall_hold[%0d]: rdy=%b last=%b tile=%0d,%0d,%0d,%0d required 1 0 %0d,%0d,%0d,%0d",
                                 s, rdy, last, tile_min_x, tile_max_x, tile_min_y, tile_max_y,
                                 ex[i][0], ex[i][1], ex[i][2], ex[i][3]);
                    end
                end
                ds_rfd = 1'b1;
            end
            vectors++;
            if ({rdy, last, tile_min_x, tile_max_x, tile_min_y, tile_max_y} !==
                {1'b1, (i == 5), ex[i][0], ex[i][1], ex[i][2], ex[i][3]}) begin
                miscompares++;
                $display("FAIL multi_tile[%0d]: rdy=%b last=%b tile=%0d,%0d,%0d,%0d required 1 %0d %0d,%0d,%0d,%0d",
                         i, rdy, last, tile_min_x, tile_max_x, tile_min_y, tile_max_y,
                         (i == 5), ex[i][0], ex[i][1], ex[i][2], ex[i][3]);
            end
            tick();
        end
        nd = 1'b0;
        vectors++;
        if ({us_rfd, rdy} !== 2'b10) begin
            miscompares++;
            $display("FAIL multi_after: us_rfd=%b rdy=%b required 1 0", us_rfd, rdy);
        end
    endtask

    task automatic test_no_wrap();
        ds_rfd = 1'b1;
        send_box(16'hFF00, 16'hFFFF, 16'h0000, 16'h0000);
        vectors++;
        if ({rdy, last, tile_min_x, tile_max_x, tile_min_y, tile_max_y} !== {2'b10, 16'hFF00, 16'hFF7F, 16'h0, 16'h0}) begin
            miscompares++;
            $display("FAIL wrap_tile0: rdy=%b last=%b tile=%h,%h,%h,%h required 1 0 ff00,ff7f,0,0",
                     rdy, last, tile_min_x, tile_max_x, tile_min_y, tile_max_y);
        end
        tick();
        vectors++;
        if ({rdy, last, tile_min_x, tile_max_x, tile_min_y, tile_max_y} !== {2'b11, 16'hFF80, 16'hFFFF, 16'h0, 16'h0}) begin
            miscompares++;
            $display("FAIL wrap_tile1: rdy=%b last=%b tile=%h,%h,%h,%h required 1 1 ff80,ffff,0,0",
                     rdy, last, tile_min_x, tile_max_x, tile_min_y, tile_max_y);
        end
        tick();
        vectors++;
        if ({us_rfd, rdy} !== 2'b10) begin
            miscompares++;
            $display("FAIL wrap_after: us_rfd=%b rdy=%b required 1 0", us_rfd, rdy);
        end
    endtask

    task automatic test_degenerate();
        logic [15:0] bx [2][4];
        bx[0] = '{16'd10, 16'd5, 16'd0, 16'd0};
        bx[1] = '{16'd0, 16'd0, 16'd8, 16'd3};
        for (int k = 0; k < 2; k++) begin
            fp_min_x = bx[k][0]; fp_max_x = bx[k][1]; fp_min_y = bx[k][2]; fp_max_y = bx[k][3];
            nd = 1'b1;
            tick();
            nd = 1'b0;
            vectors++;
            if ({err, rdy, us_rfd} !== 3'b101) begin
                miscompares++;
                $display("FAIL degen_pulse[%0d]: err/rdy/us_rfd=%b required 101", k, {err, rdy, us_rfd});
            end
            tick();
            vectors++;
            if ({err, rdy, us_rfd} !== 3'b001) begin
                miscompares++;
                $display("FAIL degen_after[%0d]: err/rdy/us_rfd=%b required 001", k, {err, rdy, us_rfd});
            end
        end
    endtask

    task automatic test_reset_mid_emit();
        ds_rfd = 1'b1;
        send_box(16'd0, 16'd300, 16'd0, 16'd130);
        tick(); tick();
        vectors++;
        if (tile_min_x !== 16'd256) begin
            miscompares++;
            $display("FAIL rst_mid_pre: tile_min_x=%0d required 256", tile_min_x);
        end
        // Reset wins over a simultaneous valid box and ds_rfd.
        fp_min_x = 16'd0; fp_max_x = 16'd127; fp_min_y = 16'd0; fp_max_y = 16'd127;
        nd = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; nd = 1'b0;
        vectors++;
        if ({us_rfd, rdy, last, tile_min_x, tile_max_x, tile_min_y, tile_max_y} !== {3'b100, 64'h0}) begin
            miscompares++;
            $display("FAIL rst_mid: us_rfd=%b rdy=%b last=%b tile=%h,%h,%h,%h required 1 0 0 zeros",
                     us_rfd, rdy, last, tile_min_x, tile_max_x, tile_min_y, tile_max_y);
        end
        tick();
        vectors++;
        if ({us_rfd, rdy} !== 2'b10) begin
            miscompares++;
            $display("FAIL rst_mid_idle: us_rfd=%b rdy=%b required 1 0", us_rfd, rdy);
        end
        send_box(16'd128, 16'd200, 16'd64, 16'd64);
        vectors++;
        if ({rdy, last, tile_min_x, tile_max_x, tile_min_y, tile_max_y} !== {2'b11, 16'd128, 16'd200, 16'd64, 16'd64}) begin
            miscompares++;
            $display("FAIL rst_fresh: rdy=%b last=%b tile=%0d,%0d,%0d,%0d required 1 1 128,200,64,64",
                     rdy, last, tile_min_x, tile_max_x, tile_min_y, tile_max_y);
        end
        tick();
        vectors++;
        if ({us_rfd, rdy} !== 2'b10) begin
            miscompares++;
            $display("FAIL rst_fresh_after: us_rfd=%b rdy=%b required 1 0", us_rfd, rdy);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single_tile();
        test_multi_tile(-1);
        test_multi_tile(1);
        test_no_wrap();
        test_degenerate();
        test_reset_mid_emit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frag_tile_scheduler.md
FRAG_TILE_SCHEDULER -- requirements
Module: frag_tile_scheduler

Interface
REQ-001 SHALL have parameter TILE_STEP, default 16'd128, tile edge in fp units (8 pixels in Q12.4); nonzero.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port nd  input  1  upstream bounding box valid.
REQ-005 SHALL have port us_rfd  output  1  scheduler ready for a new bounding box.
REQ-006 SHALL have ports fp_min_x, fp_max_x, fp_min_y, fp_max_y  input  16 each  bounding box, unsigned Q12.4, inclusive.
REQ-007 SHALL have port ds_rfd  input  1  downstream frag_iterator ready for a tile.
REQ-008 SHALL have port rdy  output  1  tile outputs valid.
REQ-009 SHALL have ports tile_min_x, tile_max_x, tile_min_y, tile_max_y  output  16 each  current tile, inclusive.
REQ-010 SHALL have port last  output  1  current tile is final tile of the bounding box; qualified by rdy.
REQ-011 SHALL have port err  output  1  one-cycle pulse when a degenerate box is dropped.

Function
REQ-012 SHALL transfer upstream only on cycles where nd && us_rfd; downstream only on cycles where rdy && ds_rfd.
REQ-013 SHALL implement FSM states IDLE and EMIT; us_rfd = 1 only in IDLE; rdy = 1 only in EMIT.
REQ-014 SHALL, in IDLE on nd with fp_min_x <= fp_max_x and fp_min_y <= fp_max_y, latch the box, set cur_x = fp_min_x, cur_y = fp_min_y, enter EMIT; rdy rises the next cycle (latency 1).
REQ-015 SHALL, in IDLE on nd with fp_min_x > fp_max_x or fp_min_y > fp_max_y, consume the box, stay IDLE, assert err for one cycle.
REQ-016 SHALL drive registered outputs tile_min_x = cur_x, tile_max_x = min(cur_x + TILE_STEP - 1, box_max_x); y likewise.
REQ-017 SHALL compute cur + TILE_STEP - 1 in 17 bits; carry out clamps the tile edge to box max (no wrap).
REQ-018 SHALL hold all tile outputs, rdy and last stable while rdy && !ds_rfd.
REQ-019 SHALL, on accept with tile_max_x != box_max_x, advance cur_x += TILE_STEP (row-major, x fastest).
REQ-020 SHALL, on accept with tile_max_x == box_max_x and tile_max_y != box_max_y, set cur_x = box_min_x, cur_y += TILE_STEP.
REQ-021 SHALL assert last = (tile_max_x == box_max_x) && (tile_max_y == box_max_y); on accept of last tile return to IDLE, us_rfd = 1 next cycle.
REQ-022 SHALL ignore nd and upstream inputs while in EMIT; box fields change only in IDLE.
REQ-023 SHALL produce exactly ceil(W/TILE_STEP)*ceil(H/TILE_STEP) tiles per box, W = max_x-min_x+1, H likewise.
REQ-024 SHALL issue a single tile with last = 1 for a box smaller than one tile, including a single-pixel box.

Reset
REQ-025 SHALL, on rst high at a clock edge, enter IDLE: us_rfd = 1, rdy = 0, last = 0, err = 0, tile outputs = 16'h0000.
REQ-026 SHALL abandon any in-progress box on reset mid-EMIT; no further tiles of that box are issued.
REQ-027 SHALL give rst priority over nd and ds_rfd in the same cycle.

Verification
REQ-028 SHALL pass: box (0,127,0,127), ds_rfd = 1 -> one tile (0,127,0,127), last = 1, us_rfd = 1 the cycle after accept.
REQ-029 SHALL pass: box x 0..300, y 0..130 -> 6 tiles in order x [0,127],[128,255],[256,300] for y [0,127], then same x for y [128,130]; last only on 6th.
REQ-030 SHALL pass: ds_rfd low 5 cycles during tile 2 of REQ-029 -> rdy and tile outputs constant; sequence resumes unchanged.
REQ-031 SHALL pass: box x 16'hFF00..16'hFFFF, y 0..0 -> tiles [FF00,FF7F],[FF80,FFFF], second with last = 1, no wrap to 0.
REQ-032 SHALL pass: nd with min_x = 10, max_x = 5 -> err = 1 for one cycle, rdy stays 0, us_rfd stays 1.
REQ-033 SHALL pass: rst asserted during tile 3 of REQ-029 -> next cycle rdy = 0, us_rfd = 1, outputs 0; new box then starts fresh.
